phrase_bank: RTL and testbench

Multi-phrase, parametrised successor to the 4-channel phrase register file. Holds NUM_PHRASES phrases of NUM_ROWS rows × NUM_CHANNELS channels of 16-bit entries.
- Playback side: registered read port that returns one full row for all channels.
- User side: write port with per-field write masks.
- Built-in clear sequencer that wipes all storage after reset, or one selected phrase on request.

---
 rtl/phrase_pkg.sv | 62 ++++++
 rtl/phrase_clear_fsm.sv | 88 ++++++++
 rtl/phrase_bank.sv | 131 +++++++++++++
 tb/tb_phrase_bank.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phrase_pkg.sv
// Shared types and constants for the phrase bank: entry layout, write-mask bits, clear FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package phrase_pkg;

   localparam int ENTRY_W = 16;
   localparam int NOTE_W  = 8;
   localparam int VOL_W   = 6;
   localparam int INST_W  = 2;
   localparam int MASK_W  = 3;

   // wr_mask bit positions
   localparam int MASK_NOTE = 2;
   localparam int MASK_VOL  = 1;
   localparam int MASK_INST = 0;

   localparam logic [NOTE_W-1:0] NOTE_EMPTY = 8'h00;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [VOL_W-1:0]  volume;
      logic [INST_W-1:0] instrument;
   } phrase_entry_t;

   typedef enum logic [1:0] {
      ST_INIT_CLEAR = 2'd0,
      ST_IDLE       = 2'd1,
      ST_CLEAR      = 2'd2
   } clr_state_t;

   // Field-wise merge: a set mask bit takes the field from new_e, otherwise old_e is kept.
   function automatic phrase_entry_t merge_entry(input phrase_entry_t old_e,
                                                 input phrase_entry_t new_e,
                                                 input logic [MASK_W-1:0] mask);
      phrase_entry_t res;
      res            = old_e;
      if (mask[MASK_NOTE]) res.note       = new_e.note;
      if (mask[MASK_VOL])  res.volume     = new_e.volume;
      if (mask[MASK_INST]) res.instrument = new_e.instrument;
      return res;
   endfunction

   // Shift the note by a signed offset, saturating to 1..255. Empty notes stay empty.
   function automatic phrase_entry_t transpose_entry(input phrase_entry_t e,
                                                     input logic signed [7:0] t);
      phrase_entry_t       res;
      logic signed [9:0]   sum;
      res = e;
      sum = $signed({2'b00, e.note}) + $signed({{2{t[7]}}, t});
      if (e.note != NOTE_EMPTY) begin
         if (sum < 10'sd1) begin
            res.note = 8'h01;
         end else if (sum > 10'sd255) begin
            res.note = 8'hFF;
         end else begin
            res.note = sum[7:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/phrase_clear_fsm.sv
// Clear sequencer: wipes all rows after reset, or one phrase on request; owns the write-port ready.
// Latency: one row cleared per cycle; clr_done pulses the cycle after the last row is written.
// Backpressure: wr_ready low while clearing or while clr_start is asserted; clr_start outside IDLE is dropped.
// Ports: clk/rst_active_high; clr_start/clr_phrase request; clr_busy/clr_done status;
//        wr_ready to the user; clr_wr_en/clr_wr_addr drive the storage row write.
module phrase_clear_fsm
   import phrase_pkg::*;
#(
   parameter int  NUM_ROWS    = 16,
   parameter int  NUM_PHRASES = 8,
   localparam int PW          = (NUM_PHRASES > 1) ? $clog2(NUM_PHRASES) : 1,
   localparam int RW          = $clog2(NUM_ROWS),
   localparam int TOTAL       = NUM_PHRASES * NUM_ROWS,
   localparam int AW          = $clog2(TOTAL)
) (
   input  logic          clk,
   input  logic          rst_active_high,
   input  logic          clr_start,
   input  logic [PW-1:0] clr_phrase,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          wr_ready,
   output logic          clr_wr_en,
   output logic [AW-1:0] clr_wr_addr
);

   clr_state_t    state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          clr_done_q, clr_done_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         state_q    <= ST_INIT_CLEAR;
         clr_addr_q <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         clr_done_q <= clr_done_d;
      end
   end

   // Next state
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_done_d = 1'b0;
      case (state_q)
         ST_INIT_CLEAR: begin
            clr_addr_d = clr_addr_q + AW'(1);
            if (clr_addr_q == AW'(TOTAL - 1)) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            // Address starts at row 0 of the latched phrase; the phrase is done when the row bits wrap.
            clr_addr_d = clr_addr_q + AW'(1);
            if (clr_addr_q[RW-1:0] == {RW{1'b1}}) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (clr_start) begin
               state_d    = ST_CLEAR;
               // Truncation drops the phrase bit when only one phrase exists.
               clr_addr_d = AW'({clr_phrase, {RW{1'b0}}});
            end
         end
         default: begin
            state_d    = ST_INIT_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      clr_busy    = (state_q != ST_IDLE);
      clr_wr_en   = (state_q != ST_IDLE);
      wr_ready    = (state_q == ST_IDLE) && !clr_start;
      clr_wr_addr = clr_addr_q;
      clr_done    = clr_done_q;
   end

endmodule

// File: rtl/phrase_bank.sv
// Multi-phrase row store: NUM_PHRASES x NUM_ROWS rows, each NUM_CHANNELS 16-bit entries, with masked writes.
// Latency: read data registered, valid one cycle after play_req; writes land at the accepting edge.
// Backpressure: writes accepted only with wr_ready; reads are always serviced, including during clears.
// Ports: play_req/phrase/row -> play_valid/play_data (channel c at bits [16c+15:16c]);
//        wr_en/phrase/row/channel/mask/data with wr_ready; clr_start/clr_phrase -> clr_busy/clr_done.
// Optional: define PHRASE_TRANSPOSE_EN to add play_transpose (signed note offset applied on read).
module phrase_bank
   import phrase_pkg::*;
#(
   parameter int  NUM_CHANNELS = 4,
   parameter int  NUM_ROWS     = 16,
   parameter int  NUM_PHRASES  = 8,
   localparam int PW           = (NUM_PHRASES > 1) ? $clog2(NUM_PHRASES) : 1,
   localparam int RW           = $clog2(NUM_ROWS),
   localparam int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int ROW_W        = ENTRY_W * NUM_CHANNELS
) (
   input  logic               clk,
   input  logic               rst_active_high,
   input  logic               play_req,
   input  logic [PW-1:0]      play_phrase,
   input  logic [RW-1:0]      play_row,
`ifdef PHRASE_TRANSPOSE_EN
   input  logic signed [7:0]  play_transpose,
`endif
   output logic               play_valid,
   output logic [ROW_W-1:0]   play_data,
   input  logic               wr_en,
   output logic               wr_ready,
   input  logic [PW-1:0]      wr_phrase,
   input  logic [RW-1:0]      wr_row,
   input  logic [CW-1:0]      wr_channel,
   input  logic [MASK_W-1:0]  wr_mask,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               clr_start,
   input  logic [PW-1:0]      clr_phrase,
   output logic               clr_busy,
   output logic               clr_done
);

   localparam int TOTAL = NUM_PHRASES * NUM_ROWS;
   localparam int AW    = $clog2(TOTAL);

   logic             clr_wr_en;
   logic [AW-1:0]    clr_wr_addr;

   logic [ROW_W-1:0] store_q [TOTAL];
   logic             store_we_d;
   logic [AW-1:0]    store_waddr_d;
   logic [ROW_W-1:0] store_wdata_d;

   logic [AW-1:0]    rd_addr;
   logic [ROW_W-1:0] rd_row, rd_row_xf;
   logic [AW-1:0]    wr_addr;
   logic [ROW_W-1:0] wr_new_row;
   logic             wr_hit;

   logic             play_valid_q, play_valid_d;
   logic [ROW_W-1:0] play_data_q, play_data_d;

   phrase_clear_fsm #(
      .NUM_ROWS    (NUM_ROWS),
      .NUM_PHRASES (NUM_PHRASES)
   ) u_clear_fsm (
      .clk             (clk),
      .rst_active_high (rst_active_high),
      .clr_start       (clr_start),
      .clr_phrase      (clr_phrase),
      .clr_busy        (clr_busy),
      .clr_done        (clr_done),
      .wr_ready        (wr_ready),
      .clr_wr_en       (clr_wr_en),
      .clr_wr_addr     (clr_wr_addr)
   );

   // Read path: the row is sampled from storage before any write at the same edge,
   // so reads during a clear or a colliding user write see the old contents.
   always_comb begin
      rd_addr   = AW'({play_phrase, play_row});
      rd_row    = store_q[rd_addr];
      rd_row_xf = rd_row;
`ifdef PHRASE_TRANSPOSE_EN
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         rd_row_xf[ENTRY_W*c +: ENTRY_W] =
            transpose_entry(phrase_entry_t'(rd_row[ENTRY_W*c +: ENTRY_W]), play_transpose);
      end
`endif
      play_valid_d = play_req;
      play_data_d  = play_req ? rd_row_xf : play_data_q;
   end

   // Write path: read-modify-write of the whole row with the selected channel merged.
   // Channel indices with no matching lane leave wr_hit low and the write is discarded.
   always_comb begin
      wr_addr    = AW'({wr_phrase, wr_row});
      wr_new_row = store_q[wr_addr];
      wr_hit     = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (wr_channel == CW'(c)) begin
            wr_hit = 1'b1;
            wr_new_row[ENTRY_W*c +: ENTRY_W] =
               merge_entry(phrase_entry_t'(wr_new_row[ENTRY_W*c +: ENTRY_W]),
                           phrase_entry_t'(wr_data), wr_mask);
         end
      end
      // Clears and user writes never coincide: wr_ready is low whenever the sequencer writes.
      store_we_d    = clr_wr_en || (wr_en && wr_ready && wr_hit);
      store_waddr_d = clr_wr_en ? clr_wr_addr : wr_addr;
      store_wdata_d = clr_wr_en ? '0 : wr_new_row;
   end

   always_ff @(posedge clk) begin
      if (store_we_d) begin
         store_q[store_waddr_d] <= store_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         play_valid_q <= 1'b0;
         play_data_q  <= '0;
      end else begin
         play_valid_q <= play_valid_d;
         play_data_q  <= play_data_d;
      end
   end

   assign play_valid = play_valid_q;
   assign play_data  = play_data_q;

endmodule

// File: tb/tb_phrase_bank.sv
module tb_phrase_bank;

   localparam int NC    = 4;
   localparam int NR    = 16;
   localparam int NP    = 8;
   localparam int TOTAL = NP * NR;
`ifdef PHRASE_TRANSPOSE_EN
   localparam bit TR_EN = 1'b1;
`else
   localparam bit TR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_active_high;
   logic              play_req;
   logic [2:0]        play_phrase;
   logic [3:0]        play_row;
   logic signed [7:0] play_transpose;
   logic              play_valid;
   logic [63:0]       play_data;
   logic              wr_en;
   logic              wr_ready;
   logic [2:0]        wr_phrase;
   logic [3:0]        wr_row;
   logic [1:0]        wr_channel;
   logic [2:0]        wr_mask;
   logic [15:0]       wr_data;
   logic              clr_start;
   logic [2:0]        clr_phrase;
   logic              clr_busy;
   logic              clr_done;

   always #5 clk = ~clk;

   phrase_bank #(
      .NUM_CHANNELS (NC),
      .NUM_ROWS     (NR),
      .NUM_PHRASES  (NP)
   ) dut (
      .clk             (clk),
      .rst_active_high (rst_active_high),
      .play_req        (play_req),
      .play_phrase     (play_phrase),
      .play_row        (play_row),
`ifdef PHRASE_TRANSPOSE_EN
      .play_transpose  (play_transpose),
`endif
      .play_valid      (play_valid),
      .play_data       (play_data),
      .wr_en           (wr_en),
      .wr_ready        (wr_ready),
      .wr_phrase       (wr_phrase),
      .wr_row          (wr_row),
      .wr_channel      (wr_channel),
      .wr_mask         (wr_mask),
      .wr_data         (wr_data),
      .clr_start       (clr_start),
      .clr_phrase      (clr_phrase),
      .clr_busy        (clr_busy),
      .clr_done        (clr_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_mem   [NP][NR][NC];
   bit          m_known [NP][NR];
   int          busy_left = 0;   // clear rows still to be written
   bit          init_mode;
   int          clr_ph;
   int          m_idx;
   bit          started   = 1'b0;
   bit          exp_valid, exp_done, exp_known;
   logic [63:0] exp_data;
   logic [15:0] old_e;

   function automatic logic [15:0] xf(input logic [15:0] e, input logic signed [7:0] t);
      int n;
      if (!TR_EN || e[15:8] == 8'h00) return e;
      n = int'(e[15:8]) + int'(t);
      if (n < 1)   n = 1;
      if (n > 255) n = 255;
      return {n[7:0], e[7:0]};
   endfunction

   always @(posedge clk) begin
      if (rst_active_high) begin
         busy_left = TOTAL;
         init_mode = 1'b1;
         exp_valid = 1'b0;
         exp_data  = '0;
         exp_known = 1'b1;
         exp_done  = 1'b0;
         started   = 1'b1;
      end else if (started) begin
         // Read sees storage as it was before this edge's write.
         if (play_req) begin
            exp_valid = 1'b1;
            exp_known = m_known[play_phrase][play_row];
            for (int c = 0; c < NC; c++)
               exp_data[16*c +: 16] = xf(m_mem[play_phrase][play_row][c], play_transpose);
         end else begin
            exp_valid = 1'b0;
         end
         exp_done = 1'b0;
         if (busy_left > 0) begin
            m_idx = init_mode ? (TOTAL - busy_left) : (clr_ph * NR + (NR - busy_left));
            for (int c = 0; c < NC; c++) m_mem[m_idx / NR][m_idx % NR][c] = 16'h0000;
            m_known[m_idx / NR][m_idx % NR] = 1'b1;
            busy_left--;
            if (busy_left == 0) exp_done = 1'b1;
         end else if (clr_start) begin
            busy_left = NR;
            init_mode = 1'b0;
            clr_ph    = int'(clr_phrase);
         end else if (wr_en) begin
            old_e = m_mem[wr_phrase][wr_row][wr_channel];
            m_mem[wr_phrase][wr_row][wr_channel] = {
               wr_mask[2] ? wr_data[15:8] : old_e[15:8],
               wr_mask[1] ? wr_data[7:2]  : old_e[7:2],
               wr_mask[0] ? wr_data[1:0]  : old_e[1:0]};
         end
      end
   end

   // Compare process: every cycle once reset has been seen.
   int done_cnt = 0;
   always @(negedge clk) begin
      if (started) begin
         check("clr_busy",   {63'd0, clr_busy},   {63'd0, busy_left > 0});
         check("wr_ready",   {63'd0, wr_ready},   {63'd0, (busy_left == 0) && !clr_start});
         check("clr_done",   {63'd0, clr_done},   {63'd0, exp_done});
         check("play_valid", {63'd0, play_valid}, {63'd0, exp_valid});
         if (exp_known) check("play_data", play_data, exp_data);
         if (clr_done) done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input int p, input int r, input int c, input logic [2:0] m,
                           input logic [15:0] d);
      wr_en = 1'b1; wr_phrase = 3'(p); wr_row = 4'(r); wr_channel = 2'(c);
      wr_mask = m; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_read(input int p, input int r);
      play_req = 1'b1; play_phrase = 3'(p); play_row = 4'(r);
      step();
      play_req = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (clr_busy && n < 400) begin
         step();
         n++;
      end
   endtask

   int n, d0;

   initial begin
      rst_active_high = 1'b1;
      play_req = 1'b0; play_phrase = '0; play_row = '0; play_transpose = '0;
      wr_en = 1'b0; wr_phrase = '0; wr_row = '0; wr_channel = '0; wr_mask = '0; wr_data = '0;
      clr_start = 1'b0; clr_phrase = '0;
      step(3);
      check("rst_busy",  {63'd0, clr_busy},   64'd1);
      check("rst_ready", {63'd0, wr_ready},   64'd0);
      check("rst_valid", {63'd0, play_valid}, 64'd0);
      check("rst_data",  play_data,           64'd0);
      rst_active_high = 1'b0;

      wait_idle(n);
      check("init_len", 64'(n), 64'd128);
      step(2);
      check("init_done_cnt", 64'(done_cnt), 64'd1);
      check("idle_ready", {63'd0, wr_ready}, 64'd1);

      for (int p = 0; p < NP; p++)
         for (int r = 0; r < NR; r++) do_read(p, r);
      check("init_zero", play_data, 64'd0);

      // Full write and read-back
      do_write(2, 5, 3, 3'b111, 16'h3C7E);
      do_read(2, 5);
      check("w_valid",  {63'd0, play_valid}, 64'd1);
      check("w_ch3",    {48'd0, play_data[63:48]}, 64'h3C7E);
      check("w_others", {16'd0, play_data[47:0]},  64'd0);
      step();
      check("valid_drop", {63'd0, play_valid}, 64'd0);
      check("data_hold",  {48'd0, play_data[63:48]}, 64'h3C7E);

      // Masked writes
      do_write(2, 5, 3, 3'b010, 16'hFF01);
      do_read(2, 5);
      check("mask_vol", {48'd0, play_data[63:48]}, 64'h3C02);
      do_write(2, 5, 3, 3'b000, 16'hFFFF);
      do_read(2, 5);
      check("mask_none", {48'd0, play_data[63:48]}, 64'h3C02);
      do_write(2, 5, 3, 3'b101, 16'h12FF);
      do_read(2, 5);
      check("mask_note_inst", {48'd0, play_data[63:48]}, 64'h1203);

      // Same-cycle read and write of one address returns old data
      wr_en = 1'b1; wr_phrase = 3'd2; wr_row = 4'd5; wr_channel = 2'd3;
      wr_mask = 3'b111; wr_data = 16'h5555;
      play_req = 1'b1; play_phrase = 3'd2; play_row = 4'd5;
      step();
      wr_en = 1'b0; play_req = 1'b0;
      check("rbw_old", {48'd0, play_data[63:48]}, 64'h1203);
      do_read(2, 5);
      check("rbw_new", {48'd0, play_data[63:48]}, 64'h5555);

      // Fill phrase 1, mark phrase 0
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) do_write(1, r, c, 3'b111, 16'(16'h1000 + r * 16 + c + 1));
      do_write(0, 3, 0, 3'b111, 16'hABCD);

      // Clear phrase 1 while a write is offered: the clear wins
      clr_start = 1'b1; clr_phrase = 3'd1;
      wr_en = 1'b1; wr_phrase = 3'd0; wr_row = 4'd3; wr_channel = 2'd0;
      wr_mask = 3'b111; wr_data = 16'h1234;
      #1;
      check("conflict_ready", {63'd0, wr_ready}, 64'd0);
      step();
      clr_start = 1'b0; wr_en = 1'b0;
      // Read phrase 1 while it is being cleared; also try a second clr_start that must be ignored
      n = 0;
      while (clr_busy && n < 400) begin
         play_req = 1'b1; play_phrase = 3'd1; play_row = 4'(n);
         clr_start = (n == 5); clr_phrase = 3'd2;
         step();
         n++;
      end
      play_req = 1'b0; clr_start = 1'b0;
      check("clr_len", 64'(n), 64'd16);
      step(2);
      check("clr_done_cnt", 64'(done_cnt), 64'd2);
      do_read(1, 7);
      check("p1_zero", play_data, 64'd0);
      do_read(0, 3);
      check("p0_kept", {48'd0, play_data[15:0]}, 64'hABCD);
      do_read(2, 5);
      check("p2_kept", {48'd0, play_data[63:48]}, 64'h5555);

      // Reset in the 7th cycle of a phrase clear
      clr_start = 1'b1; clr_phrase = 3'd2;
      step();
      clr_start = 1'b0;
      step(6);
      rst_active_high = 1'b1;
      step();
      rst_active_high = 1'b0;
      d0 = done_cnt;
      check("abort_no_done", 64'(d0), 64'd2);
      wait_idle(n);
      check("reinit_len", 64'(n), 64'd128);
      step(2);
      check("abort_done_cnt", 64'(done_cnt), 64'(d0 + 1));
      do_read(2, 5);
      check("reinit_zero", play_data, 64'd0);

      if (TR_EN) begin
         do_write(3, 0, 0, 3'b111, 16'hFA01);
         do_write(3, 0, 1, 3'b111, 16'h0207);
         do_write(3, 0, 2, 3'b111, 16'h0055);
         do_write(3, 0, 3, 3'b111, 16'h80AA);
         play_transpose = 8'sd10;
         do_read(3, 0);
         check("tr_up_clamp", {48'd0, play_data[15:0]},  64'hFF01);
         check("tr_up",       {48'd0, play_data[31:16]}, 64'h0C07);
         check("tr_up_empty", {48'd0, play_data[47:32]}, 64'h0055);
         play_transpose = -8'sd5;
         do_read(3, 0);
         check("tr_dn",       {48'd0, play_data[15:0]},  64'hF501);
         check("tr_dn_clamp", {48'd0, play_data[31:16]}, 64'h0107);
         check("tr_dn_empty", {48'd0, play_data[47:32]}, 64'h0055);
         check("tr_dn_mid",   {48'd0, play_data[63:48]}, 64'h7BAA);
         play_transpose = 8'sd0;
         do_read(3, 0);
         check("tr_store", {48'd0, play_data[15:0]}, 64'hFA01);
      end

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
